// File: rtl/timing_state_sequencer.sv
// T-state sequencer for a 6502-style core: one-hot T1..T6 timing, opcode-fetch
// strobes, and the interrupt/reset vector decision taken at each instruction boundary.
module timing_state_sequencer (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       rw,
    input  logic       end_instr,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       i_flag,
    output logic [5:0] t_state,
    output logic       sync,
    output logic       load_ir,
    output logic       force_brk,
    output logic [1:0] vec_sel,
    output logic       seq_err
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam logic [1:0] VEC_NONE = 2'b00;
    localparam logic [1:0] VEC_IRQ  = 2'b01;
    localparam logic [1:0] VEC_NMI  = 2'b10;
    localparam logic [1:0] VEC_RST  = 2'b11;

    t_state_e   r_state;
    t_state_e   w_state_nxt;
    logic       w_adv;
    logic       w_leave_last;
    logic       w_t1_exit;
    logic       w_nmi_edge;
    logic [1:0] w_vec_dec;
    logic       r_rst_pend;
    logic       r_nmi_pend;
    logic       r_nmi_prev;
    logic       r_force_brk;
    logic [1:0] r_vec_sel;
    logic       r_seq_err;

    // Writes never wait for memory, so only a read cycle with rdy low stalls.
    assign w_adv        = rdy | ~rw;
    assign w_t1_exit    = w_adv & (r_state == T1);
    assign w_leave_last = w_adv & (r_state != T1) & (w_state_nxt == T1);
    assign w_nmi_edge   = r_nmi_prev & ~nmi_n;

    // Next T-state; end_instr is ignored in T1 so every instruction spans at least two cycles.
    always_comb begin
        w_state_nxt = r_state;
        if (w_adv) begin
            case (r_state)
                T1:      w_state_nxt = T2;
                T2:      w_state_nxt = end_instr ? T1 : T3;
                T3:      w_state_nxt = end_instr ? T1 : T4;
                T4:      w_state_nxt = end_instr ? T1 : T5;
                T5:      w_state_nxt = end_instr ? T1 : T6;
                T6:      w_state_nxt = T1;
                default: w_state_nxt = T1;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Interrupt source priority evaluated at the instruction boundary.
    always_comb begin
        w_vec_dec = VEC_NONE;
        if (r_rst_pend) begin
            w_vec_dec = VEC_RST;
        end else if (r_nmi_pend) begin
            w_vec_dec = VEC_NMI;
        end else if (!irq_n && !i_flag) begin
            w_vec_dec = VEC_IRQ;
        end else begin
            w_vec_dec = VEC_NONE;
        end
    end

    // T-state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= T1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NMI edge detector runs every cycle, stalled or not.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_nmi_prev <= 1'b1;
        end else begin
            r_nmi_prev <= nmi_n;
        end
    end

    // A new edge wins over the clear so a back-to-back NMI is never lost.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_nmi_pend <= 1'b0;
        end else if (w_nmi_edge) begin
            r_nmi_pend <= 1'b1;
        end else if (w_t1_exit && (r_vec_sel == VEC_NMI)) begin
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_pend <= r_nmi_pend;
        end
    end

    // Reset pending until the reset BRK sequence has fetched its T1.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_pend <= 1'b1;
        end else if (w_t1_exit && (r_vec_sel == VEC_RST)) begin
            r_rst_pend <= 1'b0;
        end else begin
            r_rst_pend <= r_rst_pend;
        end
    end

    // Forced-BRK and vector select latched at the boundary, held through T1.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_force_brk <= 1'b1;
            r_vec_sel   <= VEC_RST;
        end else if (w_leave_last) begin
            r_force_brk <= (w_vec_dec != VEC_NONE);
            r_vec_sel   <= w_vec_dec;
        end else if (w_t1_exit) begin
            r_force_brk <= 1'b0;
            r_vec_sel   <= VEC_NONE;
        end else begin
            r_force_brk <= r_force_brk;
            r_vec_sel   <= r_vec_sel;
        end
    end

    // Sticky sequencing error: decode ran off the end of T6.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_err <= 1'b0;
        end else if (w_adv && (r_state == T6) && !end_instr) begin
            r_seq_err <= 1'b1;
        end else begin
            r_seq_err <= r_seq_err;
        end
    end

    assign t_state   = r_state;
    assign sync      = r_state[0];
    assign load_ir   = rst_n & w_t1_exit;
    assign force_brk = r_force_brk;
    assign vec_sel   = r_vec_sel;
    assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_timing_state_sequencer.sv
// Bench for timing_state_sequencer: directed vector table, async-reset sequence,
// then randomized stimulus against an instruction-level reference model.
module tb_timing_state_sequencer;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy = 1'b1, rw = 1'b1, end_instr = 1'b0;
    logic       irq_n = 1'b1, nmi_n = 1'b1, i_flag = 1'b0;
    logic [5:0] t_state;
    logic       sync, load_ir, force_brk, seq_err;
    logic [1:0] vec_sel;

    int checks = 0;
    int errors = 0;

    timing_state_sequencer dut (
        .clock(clock), .rst_n(rst_n), .rdy(rdy), .rw(rw), .end_instr(end_instr),
        .irq_n(irq_n), .nmi_n(nmi_n), .i_flag(i_flag), .t_state(t_state),
        .sync(sync), .load_ir(load_ir), .force_brk(force_brk),
        .vec_sel(vec_sel), .seq_err(seq_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rdy, rw, ei, irq_n, nmi_n, i_flag;
        logic [5:0] t;
        logic       ld, fb;
        logic [1:0] vec;
        logic       err;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic a, b, c, d, e, f, input logic [5:0] t,
                                input logic ld, fb, input logic [1:0] v, input logic er);
        vec_t x;
        x.rdy = a; x.rw = b; x.ei = c; x.irq_n = d; x.nmi_n = e; x.i_flag = f;
        x.t = t; x.ld = ld; x.fb = fb; x.vec = v; x.err = er;
        return x;
    endfunction

    // Compare all outputs as one word {t_state, sync, load_ir, force_brk, vec_sel, seq_err}.
    task automatic check(input string name, input logic [5:0] t, input logic sy, ld, fb,
                         input logic [1:0] v, input logic er);
        logic [11:0] act, exp;
        act = {t_state, sync, load_ir, force_brk, vec_sel, seq_err};
        exp = {t, sy, ld, fb, v, er};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got t=%b sync=%b ld=%b fb=%b vec=%b err=%b, want t=%b sync=%b ld=%b fb=%b vec=%b err=%b",
                     name, t_state, sync, load_ir, force_brk, vec_sel, seq_err, t, sy, ld, fb, v, er);
        end
    endtask

    task automatic set_in(input logic a, b, c, d, e, f);
        rdy = a; rw = b; end_instr = c; irq_n = d; nmi_n = e; i_flag = f;
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 check("reset_hold", 6'b000001, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    // Reference model: instruction-level view with a numeric T-state 1..6.
    int         m_n;
    bit         m_rst_pend, m_nmi_pend, m_nmi_prev, m_fb, m_err;
    logic [1:0] m_vec;

    task automatic model_reset();
        m_n = 1; m_rst_pend = 1; m_nmi_pend = 0; m_nmi_prev = 1;
        m_fb = 1; m_vec = 2'b11; m_err = 0;
    endtask

    task automatic model_step();
        bit adv, edge_seen, old_nmi, last;
        adv       = rdy || !rw;
        edge_seen = m_nmi_prev && !nmi_n;
        m_nmi_prev = nmi_n;
        old_nmi   = m_nmi_pend;
        if (adv) begin
            if (m_n == 1) begin
                if (m_vec == 2'b11) m_rst_pend = 0;
                if (m_vec == 2'b10) m_nmi_pend = 0;
                m_fb = 0; m_vec = 2'b00; m_n = 2;
            end else begin
                last = (m_n == 6) || end_instr;
                if (m_n == 6 && !end_instr) m_err = 1;
                if (last) begin
                    if (m_rst_pend)              m_vec = 2'b11;
                    else if (old_nmi)            m_vec = 2'b10;
                    else if (!irq_n && !i_flag)  m_vec = 2'b01;
                    else                         m_vec = 2'b00;
                    m_fb = (m_vec != 2'b00);
                    m_n = 1;
                end else begin
                    m_n = m_n + 1;
                end
            end
        end
        if (edge_seen) m_nmi_pend = 1;
    endtask

    initial begin
        tbl[0]  = mk(1,1,0,1,1,0, 6'h01, 1,1, 2'd3, 0);
        tbl[1]  = mk(1,1,1,1,1,0, 6'h02, 0,0, 2'd0, 0);
        tbl[2]  = mk(1,1,0,1,1,0, 6'h01, 1,0, 2'd0, 0);
        tbl[3]  = mk(1,1,0,1,1,0, 6'h02, 0,0, 2'd0, 0);
        tbl[4]  = mk(0,1,0,1,1,0, 6'h04, 0,0, 2'd0, 0);
        tbl[5]  = mk(0,1,0,1,1,0, 6'h04, 0,0, 2'd0, 0);
        tbl[6]  = mk(0,1,0,1,1,0, 6'h04, 0,0, 2'd0, 0);
        tbl[7]  = mk(1,1,0,1,1,0, 6'h04, 0,0, 2'd0, 0);
        tbl[8]  = mk(0,0,0,1,1,0, 6'h08, 0,0, 2'd0, 0);
        tbl[9]  = mk(1,1,1,1,1,0, 6'h10, 0,0, 2'd0, 0);
        tbl[10] = mk(1,1,0,1,1,0, 6'h01, 1,0, 2'd0, 0);
        tbl[11] = mk(1,1,0,1,1,0, 6'h02, 0,0, 2'd0, 0);
        tbl[12] = mk(1,1,0,0,0,0, 6'h04, 0,0, 2'd0, 0);
        tbl[13] = mk(1,1,1,0,0,0, 6'h08, 0,0, 2'd0, 0);
        tbl[14] = mk(1,1,0,0,1,0, 6'h01, 1,1, 2'd2, 0);
        tbl[15] = mk(1,1,1,0,1,0, 6'h02, 0,0, 2'd0, 0);
        tbl[16] = mk(1,1,0,1,1,1, 6'h01, 1,1, 2'd1, 0);
        tbl[17] = mk(1,1,1,0,1,1, 6'h02, 0,0, 2'd0, 0);
        tbl[18] = mk(1,1,0,1,1,0, 6'h01, 1,0, 2'd0, 0);
        tbl[19] = mk(1,1,0,1,1,0, 6'h02, 0,0, 2'd0, 0);
        tbl[20] = mk(1,1,0,1,1,0, 6'h04, 0,0, 2'd0, 0);
        tbl[21] = mk(1,1,0,1,1,0, 6'h08, 0,0, 2'd0, 0);
        tbl[22] = mk(1,1,0,1,1,0, 6'h10, 0,0, 2'd0, 0);
        tbl[23] = mk(1,1,0,1,1,0, 6'h20, 0,0, 2'd0, 0);
        tbl[24] = mk(1,1,0,1,1,0, 6'h01, 1,0, 2'd0, 1);
        tbl[25] = mk(1,1,0,1,1,0, 6'h02, 0,0, 2'd0, 1);

        do_reset();
        for (int k = 0; k < 26; k++) begin
            set_in(tbl[k].rdy, tbl[k].rw, tbl[k].ei, tbl[k].irq_n, tbl[k].nmi_n, tbl[k].i_flag);
            #1 check($sformatf("table_row%0d", k), tbl[k].t, tbl[k].t[0], tbl[k].ld,
                     tbl[k].fb, tbl[k].vec, tbl[k].err);
            @(negedge clock);
        end

        // Async reset while stalled in T4; also clears the sticky seq_err.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 check("stall_t4", 6'b001000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 6'b000001, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        @(negedge clock);
        rst_n = 1'b1;
        #1 check("post_reset_stalled_t1", 6'b000001, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        rdy = 1'b1;
        #1 check("post_reset_t1_fetch", 6'b000001, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);

        // Randomized phase against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                model_reset();
            end
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 9) < 4, $urandom_range(0, 3) != 0,
                   ($urandom_range(0, 7) != 0) ? nmi_n : ~nmi_n, $urandom_range(0, 1));
            #1 check("random", 6'(1 << (m_n - 1)), m_n == 1,
                     (m_n == 1) && (rdy || !rw), m_fb, m_vec, m_err);
            @(posedge clock);
            model_step();
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timing_state_sequencer.md
TIMING_STATE_SEQUENCER -- requirements
Module: timing_state_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clock  in  1  single system clock; all state updates on the rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous assert, active low.
REQ-004 Port: rdy  in  1  ready; low stalls read cycles.
REQ-005 Port: rw  in  1  current bus cycle direction from random control (1 = read, 0 = write).
REQ-006 Port: end_instr  in  1  decode says the current T-state is the last of the instruction.
REQ-007 Port: irq_n  in  1  maskable interrupt, level-sensitive, active low.
REQ-008 Port: nmi_n  in  1  non-maskable interrupt, falling-edge-sensitive.
REQ-009 Port: i_flag  in  1  processor I flag; 1 masks irq_n.
REQ-010 Port: t_state  out  6  one-hot T1..T6 (bit0 = T1).
REQ-011 Port: sync  out  1  high while t_state is T1 (opcode fetch).
REQ-012 Port: load_ir  out  1  single-cycle pulse; commit predecode to instruction register.
REQ-013 Port: force_brk  out  1  instruction register loads 0x00 instead of fetched opcode.
REQ-014 Port: vec_sel  out  2  00 none/BRK, 01 IRQ, 10 NMI, 11 RESET.
REQ-015 Port: seq_err  out  1  sticky; T6 reached without end_instr.

Function
REQ-016 Advance condition: adv = rdy OR NOT rw; no register changes state when adv = 0, except the NMI edge detector.
REQ-017 With adv = 1: T1 goes to T2; Tn (n = 2..5) goes to T1 if end_instr = 1, else to Tn+1.
REQ-018 With adv = 1 at T6: next state is T1 regardless of end_instr; if end_instr = 0, seq_err sets and holds until reset.
REQ-019 end_instr sampled during T1 is ignored; every instruction spans at least 2 cycles.
REQ-020 sync is a combinational decode of t_state bit0.
REQ-021 load_ir is asserted combinationally when t_state = T1 AND adv = 1; otherwise it is 0.
REQ-022 nmi_n is registered each cycle; prev = 1 and current = 0 sets nmi_pend; a stall does not mask this.
REQ-023 Interrupt decision: registered on the cycle whose next state is T1 (adv = 1, leaving the last T-state).
REQ-024 Priority at the decision point: rst_pend, then nmi_pend, then (irq_n = 0 AND i_flag = 0), then none.
REQ-025 On a taken interrupt: force_brk = 1 and vec_sel = source code, both held through the whole following T1 and cleared on T1 exit.
REQ-026 With no interrupt taken: force_brk = 0 and vec_sel = 00.
REQ-027 rst_pend clears on exit from a T1 with vec_sel = 11.
REQ-028 nmi_pend clears on exit from a T1 with vec_sel = 10.
REQ-029 Simultaneous new NMI edge and nmi_pend clear in the same cycle: pending stays set.
REQ-030 IRQ is not latched; deassertion before the decision point means no interrupt.

Reset
REQ-031 While rst_n = 0, the following values SHALL hold:
- t_state = 000001, sync = 1, load_ir = 0;
- force_brk = 1, vec_sel = 11;
- rst_pend = 1, nmi_pend = 0, seq_err = 0;
- NMI edge register = 1.
REQ-032 Reset asserted mid-instruction SHALL abort immediately to the reset values above, including with rdy low.
REQ-033 First cycle after release SHALL be T1 with forced BRK and RESET vector.

Verification
REQ-034 Reset release, rdy = 1, rw = 1, end_instr = 1 at T2:
- t_state 000001 -> 000010 -> 000001;
- force_brk = 1, vec_sel = 11 in the first T1 only;
- load_ir pulses in each T1.
REQ-035 Stall in T3 with rdy = 0, rw = 1 for 3 cycles:
- t_state holds 000100 for those 3 cycles, then advances;
- same stall with rw = 0 does not hold.
REQ-036 nmi_n 1 -> 0 during T3 of a 4-cycle instruction, irq_n = 0, i_flag = 0:
- next T1 has vec_sel = 10;
- following instruction's T1 has vec_sel = 01.
REQ-037 irq_n = 0 with i_flag = 1 through end_instr: next T1 has force_brk = 0, vec_sel = 00.
REQ-038 end_instr held 0 through T6:
- t_state wraps to 000001;
- seq_err = 1 and stays 1 until rst_n pulse.
REQ-039 rst_n pulsed low in T4 with rdy = 0: outputs asynchronously return to reset values.
